// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master: FSM states, bus constants, quarter indices.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_MADDR,
        ST_MADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_MNACK,
        ST_STOP
    } state_t;

    localparam logic [6:0] I2C_SLAVE_ID = 7'b1010101;
    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic state_t ack_state(input state_t s);
        case (s)
            ST_ADDR:  ack_state = ST_ADDR_ACK;
            ST_MADDR: ack_state = ST_MADDR_ACK;
            default:  ack_state = ST_WDATA_ACK;
        endcase
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Divides clk into SCL quarter ticks (one every CLK_DIV cycles) and tracks the quarter index.
// Held at zero while disabled; i_freeze stalls both counter and quarter index.
module i2c_quarter_timer
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_freeze,
    output logic       o_tick,
    output logic [1:0] o_qtr
);
    import i2c_pkg::*;

    generate
        if (CLK_DIV < 2 || CLK_DIV > 1023) begin : g_div_chk
            $error("i2c_quarter_timer: CLK_DIV must be in 2..1023");
        end
    endgenerate

    localparam logic [9:0] CNT_MAX = 10'(CLK_DIV - 1);

    logic [9:0] r_cnt;
    logic [1:0] r_qtr;

    assign o_tick = i_en && !i_freeze && (r_cnt == CNT_MAX);
    assign o_qtr  = r_qtr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_qtr <= Q0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_qtr <= Q0;
        end else if (!i_freeze) begin
            if (o_tick) begin
                r_cnt <= '0;
                r_qtr <= r_qtr + 2'd1;
            end else begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master: one byte write (dev, mem addr, data) or current-address read per cmd handshake;
// cmd_ready only in IDLE, commands while busy are dropped. SCL stretching under I2C_MASTER_STRETCH_EN.
module i2c_master_ctrl
#(
    parameter int CLK_DIV = 4,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [6:0]    cmd_dev_addr,
    input  logic [AW-1:0] cmd_mem_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_ack_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic          scl_o,
    input  logic          scl_i,
    output logic          sda_oe,
    input  logic          sda_i
);
    import i2c_pkg::*;

    generate
        if (AW != 8) begin : g_aw_chk
            $error("i2c_master_ctrl: AW must be 8");
        end
        if (DW != 8) begin : g_dw_chk
            $error("i2c_master_ctrl: DW must be 8");
        end
    endgenerate

    state_t     r_state;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_maddr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_rw;
    logic       r_ack_err;
    logic       r_scl;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_rsp_vld;
    logic       r_rsp_err;

    logic       w_tick;
    logic       w_freeze;
    logic [1:0] w_qtr;
    logic       w_accept;

`ifdef I2C_MASTER_STRETCH_EN
    assign w_freeze = r_scl && !scl_i && (w_qtr == Q2 || w_qtr == Q3);
`else
    assign w_freeze = 1'b0 & scl_i;
`endif

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_busy),
        .i_freeze (w_freeze),
        .o_tick   (w_tick),
        .o_qtr    (w_qtr)
    );

    assign w_accept    = cmd_valid && (r_state == ST_IDLE);
    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = r_busy;
    assign scl_o       = r_scl;
    assign sda_oe      = r_sda_oe;
    assign rsp_valid   = r_rsp_vld;
    assign rsp_ack_err = r_rsp_err;
    assign rsp_rdata   = r_rdata;

    // Q1 tick = Q2 entry (SCL rises), Q2 tick = Q3 entry (sample), Q3 tick = next bit's Q0 entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit     <= 3'd7;
            r_shift   <= '0;
            r_maddr   <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rw      <= RW_WRITE;
            r_ack_err <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            if (w_accept) begin
                r_state   <= ST_START;
                r_busy    <= 1'b1;
                r_rw      <= cmd_rw;
                r_maddr   <= cmd_mem_addr;
                r_wdata   <= cmd_wdata;
                r_shift   <= {cmd_dev_addr, cmd_rw};
                r_bit     <= 3'd7;
                r_ack_err <= 1'b0;
                r_scl     <= 1'b1;
                r_sda_oe  <= 1'b0;
            end else if (w_tick) begin
                case (w_qtr)
                    Q1: begin
                        r_scl <= 1'b1;
                        if (r_state == ST_START) r_sda_oe <= 1'b1;
                    end
                    Q2: begin
                        case (r_state)
                            ST_ADDR_ACK, ST_MADDR_ACK, ST_WDATA_ACK:
                                if (sda_i) r_ack_err <= 1'b1;
                            ST_RDATA: r_shift  <= {r_shift[6:0], sda_i};
                            ST_STOP:  r_sda_oe <= 1'b0;
                            default:  ;
                        endcase
                    end
                    Q3: begin
                        r_scl <= 1'b0;
                        case (r_state)
                            ST_START: begin
                                r_state  <= ST_ADDR;
                                r_sda_oe <= ~r_shift[7];
                            end
                            ST_ADDR, ST_MADDR, ST_WDATA: begin
                                if (r_bit == 3'd0) begin
                                    r_state  <= ack_state(r_state);
                                    r_bit    <= 3'd7;
                                    r_sda_oe <= 1'b0;
                                end else begin
                                    r_bit    <= 3'(r_bit - 3'd1);
                                    r_shift  <= {r_shift[6:0], 1'b0};
                                    r_sda_oe <= ~r_shift[6];
                                end
                            end
                            ST_ADDR_ACK: begin
                                if (r_ack_err) begin
                                    r_state  <= ST_STOP;
                                    r_sda_oe <= 1'b1;
                                end else if (r_rw == RW_READ) begin
                                    r_state  <= ST_RDATA;
                                    r_sda_oe <= 1'b0;
                                end else begin
                                    r_state  <= ST_MADDR;
                                    r_shift  <= r_maddr;
                                    r_sda_oe <= ~r_maddr[7];
                                end
                            end
                            ST_MADDR_ACK: begin
                                if (r_ack_err) begin
                                    r_state  <= ST_STOP;
                                    r_sda_oe <= 1'b1;
                                end else begin
                                    r_state  <= ST_WDATA;
                                    r_shift  <= r_wdata;
                                    r_sda_oe <= ~r_wdata[7];
                                end
                            end
                            ST_RDATA: begin
                                if (r_bit == 3'd0) begin
                                    r_state <= ST_MNACK;
                                    r_bit   <= 3'd7;
                                end else begin
                                    r_bit <= 3'(r_bit - 3'd1);
                                end
                            end
                            ST_WDATA_ACK, ST_MNACK: begin
                                r_state  <= ST_STOP;
                                r_sda_oe <= 1'b1;
                            end
                            ST_STOP: begin
                                r_state   <= ST_IDLE;
                                r_scl     <= 1'b1;
                                r_busy    <= 1'b0;
                                r_rsp_vld <= 1'b1;
                                r_rsp_err <= r_ack_err;
                                if (r_rw == RW_READ) r_rdata <= r_shift;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a behavioural I2C slave (ID 0x55) and response/bus-byte scoreboards.
module tb_i2c_master_ctrl;

    localparam int         D      = 4;
    localparam logic [6:0] SLV_ID = 7'h55;
`ifdef I2C_MASTER_STRETCH_EN
    localparam int STRETCH_LAT = 116 * D + 1 + 20;
`else
    localparam int STRETCH_LAT = 116 * D + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_addr = '0;
    logic [7:0] cmd_mem_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_ack_err, busy, scl_o, sda_oe;
    logic [7:0] rsp_rdata;
    logic       hold = 1'b0;
    logic       s_pull = 1'b0;
    logic       sda, scl_i;

    assign sda   = ~(sda_oe | s_pull);
    assign scl_i = scl_o & ~hold;

    i2c_master_ctrl #(.CLK_DIV(D), .AW(8), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_mem_addr (cmd_mem_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ack_err  (rsp_ack_err),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .scl_o        (scl_o),
        .scl_i        (scl_i),
        .sda_oe       (sda_oe),
        .sda_i        (sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic       rd;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    logic [7:0] eb_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rsp_cnt = 0;
    int         tgt = 0;
    logic [7:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: latency is measured accept cycle -> rsp_valid cycle.
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        int   a;
        if (!rst) begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (rsp_valid) begin
                rsp_cnt++;
                chk("busy_at_rsp", busy, 0);
                chk("ready_at_rsp", cmd_ready, 1);
                chk("rsp_expected", exp_q.size() > 0 && acc_q.size() > 0, 1);
                if (exp_q.size() > 0 && acc_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    if (e.rd) last_rd = e.rdata;
                    chk("ack_err", rsp_ack_err, e.err);
                    chk("rdata", rsp_rdata, last_rd);
                    chk("latency", cyc - a, e.lat);
                end
            end
        end
    end

    // Behavioural slave: ACKs its ID, keeps a byte memory with a current-address pointer.
    logic [7:0] mem [256];
    logic       s_act, s_ackph, s_rd, s_mn, p_scl, p_sda;
    logic [7:0] s_shift, s_ptr, s_rdbyte;
    int         s_bit, s_idx, s_rdcnt;

    always @(negedge clk or posedge rst) begin : slave
        if (rst) begin
            s_pull = 1'b0; s_act = 1'b0; s_ackph = 1'b0; s_rd = 1'b0; s_mn = 1'b0;
            p_scl = 1'b1; p_sda = 1'b1; s_bit = 0; s_idx = 0; s_rdcnt = 0;
        end else begin
            if (scl_o && p_scl && p_sda && !sda) begin
                s_act = 1'b1; s_bit = 0; s_idx = 0; s_ackph = 1'b0;
                s_rd = 1'b0; s_mn = 1'b0; s_pull = 1'b0;
            end else if (scl_o && p_scl && !p_sda && sda) begin
                s_act = 1'b0; s_pull = 1'b0;
            end else if (s_act && scl_o && !p_scl) begin
                if (s_mn) begin
                    chk("mnack_released", sda, 1);
                    s_mn = 1'b0; s_act = 1'b0;
                end else if (!s_rd && !s_ackph) begin
                    s_shift = {s_shift[6:0], sda};
                    s_bit++;
                end
            end else if (s_act && !scl_o && p_scl) begin
                if (s_ackph) begin
                    s_ackph = 1'b0; s_pull = 1'b0; s_bit = 0;
                    if (s_rd) begin
                        s_rdcnt = 7; s_rdbyte = mem[s_ptr]; s_pull = !s_rdbyte[7];
                    end
                end else if (s_rd) begin
                    if (s_rdcnt == 0) begin
                        s_pull = 1'b0; s_mn = 1'b1; s_rd = 1'b0;
                    end else begin
                        s_rdcnt--; s_pull = !s_rdbyte[s_rdcnt];
                    end
                end else if (s_bit == 8) begin
                    chk("bus_byte_expected", eb_q.size() > 0, 1);
                    if (eb_q.size() > 0) chk("bus_byte", s_shift, eb_q.pop_front());
                    if (s_idx == 0) begin
                        if (s_shift[7:1] == SLV_ID) begin
                            s_pull = 1'b1; s_ackph = 1'b1; s_rd = s_shift[0];
                        end else begin
                            s_act = 1'b0;
                        end
                    end else begin
                        if (s_idx == 1) s_ptr = s_shift;
                        else mem[s_ptr] = s_shift;
                        s_pull = 1'b1; s_ackph = 1'b1;
                    end
                    s_idx++;
                end
            end
            p_scl = scl_o;
            p_sda = sda;
        end
    end

    // Drives one command from a cycle where the DUT is idle; fields are scrambled after acceptance.
    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] ma,
                        input logic [7:0] wd, input logic err, input logic [7:0] rd, input int lat);
        exp_t e;
        e.err = err; e.rd = rw; e.rdata = rd; e.lat = lat;
        exp_q.push_back(e);
        eb_q.push_back({dev, rw});
        if (!rw && !err) begin
            eb_q.push_back(ma);
            eb_q.push_back(wd);
        end
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = ma; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_dev_addr = ~dev; cmd_mem_addr = ~ma; cmd_wdata = ~wd;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("rsp_count", rsp_cnt, target);
        chk("bus_bytes_left", eb_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl_o, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ack_err", rsp_ack_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", cmd_ready, 1);

        send(1'b0, SLV_ID, 8'h3C, 8'hA5, 1'b0, 8'h00, 116 * D + 1);
        tgt++; wait_rsp(tgt);

        send(1'b1, SLV_ID, 8'h00, 8'h00, 1'b0, 8'hA5, 80 * D + 1);
        tgt++; wait_rsp(tgt);

        send(1'b0, 7'h2A, 8'h11, 8'h22, 1'b1, 8'h00, 44 * D + 1);
        tgt++; wait_rsp(tgt);

        // SCL held low by the bench during ADDR bit 0 Q2 for 20 cycles.
        send(1'b0, SLV_ID, 8'h10, 8'h5A, 1'b0, 8'h00, STRETCH_LAT);
        repeat (136) @(posedge clk);
        #1;
        hold = 1'b1;
        chk("stretch_scl_high", scl_o, 1);
        chk("busy_mid", busy, 1);
        chk("ready_mid", cmd_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        hold = 1'b0;
        tgt++; wait_rsp(tgt);

        send(1'b0, SLV_ID, 8'h20, 8'h33, 1'b0, 8'h00, 116 * D + 1);
        repeat (50) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_dev_addr = SLV_ID;
        chk("ready_while_busy", cmd_ready, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tgt++; wait_rsp(tgt);

        send(1'b1, SLV_ID, 8'h00, 8'h00, 1'b0, 8'h33, 80 * D + 1);
        tgt++; wait_rsp(tgt);

        // Reset in WDATA bit 3 (data 0xF0 keeps SDA pulled low there).
        send(1'b0, SLV_ID, 8'h3C, 8'hF0, 1'b0, 8'h00, 116 * D + 1);
        repeat (369) @(posedge clk);
        #1;
        chk("pre_rst_scl", scl_o, 0);
        chk("pre_rst_sda_oe", sda_oe, 1);
        rst = 1'b1;
        #1;
        chk("midrst_scl", scl_o, 1);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        exp_q.delete();
        acc_q.delete();
        eb_q.delete();
        last_rd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send(1'b1, SLV_ID, 8'h00, 8'h00, 1'b0, 8'hA5, 80 * D + 1);
        tgt++; wait_rsp(tgt);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
